peripheral_uart_ahb2apb: RTL and testbench

- AHB3-Lite slave to APB master bridge that sits directly upstream of the UART APB bus interface.
- Converts single AHB transfers into APB SETUP/ACCESS sequences.
- Steers byte lanes so that byte accesses to UART registers 0..7 reach PWDATA[7:0] and return on the correct HRDATA lane.
- Maps PSLVERR to the AHB two-cycle ERROR response.

---
 rtl/peripheral_uart_ahb2apb_pkg.sv | 34 +++
 rtl/peripheral_uart_ahb2apb_if.sv | 57 +++++
 rtl/peripheral_uart_ahb2apb_lane.sv | 49 ++++
 rtl/peripheral_uart_ahb2apb.sv | 166 ++++++++++++++++
 tb/tb_peripheral_uart_ahb2apb.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/peripheral_uart_ahb2apb_pkg.sv
// Purpose : shared AHB encodings, bridge state type and APB4 protection helper.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: PERIPHERAL_UART_AHB2APB_APB4_EN (uses pprot_from_hprot).
package peripheral_uart_ahb2apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // APB PPROT = {instruction/data, secure, privileged} from AHB HPROT[1:0].
  function automatic logic [2:0] pprot_from_hprot(input logic [1:0] hprot);
    return {~hprot[0], 1'b0, hprot[1]};
  endfunction

endpackage

// File: rtl/peripheral_uart_ahb2apb_if.sv
// Purpose : AHB3-Lite slave side and APB master side signals of the bridge.
// Latency : n/a (wiring only).
// Backpressure: HREADYOUT (AHB) and PREADY (APB) carry the stall.
// Ports   : modport slave = bridge view, modport master = bus environment view.
// Optional feature macro: PERIPHERAL_UART_AHB2APB_APB4_EN adds PSTRB and PPROT.
interface peripheral_uart_ahb2apb_if #(
  parameter int HADDR_WIDTH    = 32,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32
);
  // AHB side
  logic                      HSEL;
  logic [HADDR_WIDTH-1:0]    HADDR;
  logic [DATA_WIDTH-1:0]     HWDATA;
  logic [DATA_WIDTH-1:0]     HRDATA;
  logic                      HWRITE;
  logic [2:0]                HSIZE;
  logic [2:0]                HBURST;
  logic [3:0]                HPROT;
  logic [1:0]                HTRANS;
  logic                      HMASTLOCK;
  logic                      HREADY;
  logic                      HREADYOUT;
  logic                      HRESP;
  // APB side
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;
`ifdef PERIPHERAL_UART_AHB2APB_APB4_EN
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic [2:0]                PPROT;
`endif

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
           HMASTLOCK, HREADY, PRDATA, PREADY, PSLVERR,
    output HRDATA, HREADYOUT, HRESP, PADDR, PWDATA, PWRITE, PSEL, PENABLE
`ifdef PERIPHERAL_UART_AHB2APB_APB4_EN
    , output PSTRB, PPROT
`endif
  );

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
           HMASTLOCK, HREADY, PRDATA, PREADY, PSLVERR,
    input  HRDATA, HREADYOUT, HRESP, PADDR, PWDATA, PWRITE, PSEL, PENABLE
`ifdef PERIPHERAL_UART_AHB2APB_APB4_EN
    , input PSTRB, PPROT
`endif
  );

endinterface

// File: rtl/peripheral_uart_ahb2apb_lane.sv
// Purpose : combinational byte-lane steering (write: AHB lane -> low APB lanes + strobe;
//           read: low APB lanes replicated onto every AHB lane).
// Latency : 0 cycles. Backpressure: none (pure logic).
// Ports   : i_size (HSIZE), i_addr_lo (address bits [1:0]), i_dat in, o_dat/o_strb out.
module peripheral_uart_ahb2apb_lane
  import peripheral_uart_ahb2apb_pkg::*;
#(
  parameter bit IS_WRITE = 1'b1
) (
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_dat,
  output logic [31:0] o_dat,
  output logic [3:0]  o_strb
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_dat[7:0];
    w_half = i_addr_lo[1] ? i_dat[31:16] : i_dat[15:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_dat[15:8];
      2'd2:    w_byte = i_dat[23:16];
      2'd3:    w_byte = i_dat[31:24];
      default: w_byte = i_dat[7:0];
    endcase

    o_dat  = i_dat;
    o_strb = 4'b0000;
    if (IS_WRITE) begin
      // The UART sits on PWDATA[7:0], so narrow writes are moved down to lane 0.
      case (i_size)
        HSIZE_BYTE: begin o_dat = {24'h0, w_byte}; o_strb = 4'b0001; end
        HSIZE_HALF: begin o_dat = {16'h0, w_half}; o_strb = 4'b0011; end
        default:    o_strb = 4'b1111;
      endcase
    end else begin
      // Replicate so the master finds the data on whichever lane it addressed.
      case (i_size)
        HSIZE_BYTE: o_dat = {4{i_dat[7:0]}};
        HSIZE_HALF: o_dat = {2{i_dat[15:0]}};
        default:    o_dat = i_dat;
      endcase
    end
  end

endmodule

// File: rtl/peripheral_uart_ahb2apb.sv
// Purpose : AHB3-Lite slave to APB master bridge in front of the UART register block.
// Latency : read ready in cycle 3, write in cycle 4 after the address phase (+1 per PREADY=0 cycle).
// Backpressure: HREADYOUT low while the APB transfer runs; PREADY low stretches ACCESS.
// Ports   : CLK, RSTN (async active-low), bus (peripheral_uart_ahb2apb_if.slave).
// Optional feature macro: PERIPHERAL_UART_AHB2APB_APB4_EN adds registered PSTRB/PPROT.
module peripheral_uart_ahb2apb
  import peripheral_uart_ahb2apb_pkg::*;
#(
  parameter int HADDR_WIDTH    = 32,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32   // only 32 is supported
) (
  input logic CLK,
  input logic RSTN,
  peripheral_uart_ahb2apb_if.slave bus
);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic                      r_pwrite;
  logic [DATA_WIDTH-1:0]     r_pwdata;
  logic [DATA_WIDTH-1:0]     r_hrdata;
  logic [2:0]                r_size;
  logic                      w_accept;
  logic                      w_size_err;
  logic                      w_hreadyout;
  logic                      w_hresp;
  logic                      w_psel;
  logic                      w_penable;
  logic [31:0]               w_wr_dat;
  logic [31:0]               w_rd_dat;
  logic [3:0]                w_wr_strb;
  logic [3:0]                w_rd_strb;
  logic [HADDR_WIDTH-1:0]    w_haddr_unused;
  logic                      w_unused;

  // New transfers are only taken when no earlier one is outstanding.
  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                    bus.HSEL && bus.HREADY &&
                    ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));
  assign w_size_err = (bus.HSIZE > HSIZE_WORD);

  peripheral_uart_ahb2apb_lane #(.IS_WRITE(1'b1)) u_lane_wr (
    .i_size    (r_size),
    .i_addr_lo (r_paddr[1:0]),
    .i_dat     (bus.HWDATA),
    .o_dat     (w_wr_dat),
    .o_strb    (w_wr_strb)
  );

  peripheral_uart_ahb2apb_lane #(.IS_WRITE(1'b0)) u_lane_rd (
    .i_size    (r_size),
    .i_addr_lo (r_paddr[1:0]),
    .i_dat     (bus.PRDATA),
    .o_dat     (w_rd_dat),
    .o_strb    (w_rd_strb)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hreadyout = 1'b1;
    w_hresp     = HRESP_OKAY;
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_size_err)      w_state_nxt = ST_ERR1;
          else if (bus.HWRITE) w_state_nxt = ST_WDATA;
          else                 w_state_nxt = ST_SETUP;
        end
      end
      ST_WDATA: begin
        w_hreadyout = 1'b0;
        w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        w_hreadyout = 1'b0;
        w_psel      = 1'b1;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_hreadyout = 1'b0;
        w_psel      = 1'b1;
        w_penable   = 1'b1;
        if (bus.PREADY) w_state_nxt = bus.PSLVERR ? ST_ERR1 : ST_DONE;
      end
      ST_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = HRESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        // Master cancels its pipelined transfer here, so nothing is accepted.
        w_hresp     = HRESP_ERROR;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef PERIPHERAL_UART_AHB2APB_APB4_EN
  logic [3:0] r_pstrb;
  logic [2:0] r_pprot;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_pstrb <= 4'b0000;
      r_pprot <= 3'b000;
    end else begin
      if (w_accept) begin
        r_pprot <= pprot_from_hprot(bus.HPROT[1:0]);
        if (!bus.HWRITE) r_pstrb <= 4'b0000;
      end
      if (r_state == ST_WDATA) r_pstrb <= w_wr_strb;
    end
  end

  assign bus.PSTRB = r_pstrb;
  assign bus.PPROT = r_pprot;
  assign w_unused  = ^{w_haddr_unused, bus.HBURST, bus.HMASTLOCK, bus.HPROT[3:2], w_rd_strb};
`else
  assign w_unused  = ^{w_haddr_unused, bus.HBURST, bus.HMASTLOCK, bus.HPROT, w_rd_strb, w_wr_strb};
`endif

  assign w_haddr_unused = bus.HADDR;

  // APB address/control are loaded at accept so they are already valid in SETUP
  // and cannot move until the next accept, which is impossible before DONE.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_hrdata <= '0;
      r_size   <= HSIZE_BYTE;
    end else begin
      if (w_accept) begin
        r_paddr  <= bus.HADDR[APB_ADDR_WIDTH-1:0];
        r_pwrite <= bus.HWRITE;
        r_size   <= bus.HSIZE;
        if (!bus.HWRITE) r_pwdata <= '0;
      end
      if (r_state == ST_WDATA) r_pwdata <= w_wr_dat;
      if ((r_state == ST_ACCESS) && bus.PREADY && !bus.PSLVERR && !r_pwrite)
        r_hrdata <= w_rd_dat;
    end
  end

  assign bus.PADDR     = r_paddr;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PWDATA    = r_pwdata;
  assign bus.PSEL      = w_psel;
  assign bus.PENABLE   = w_penable;
  assign bus.HRDATA    = r_hrdata;
  assign bus.HREADYOUT = w_hreadyout;
  assign bus.HRESP     = w_hresp;

endmodule

// File: tb/tb_peripheral_uart_ahb2apb.sv
// Purpose : directed self-checking bench for the AHB-to-APB UART bridge.
// Latency : n/a. Backpressure: PREADY wait states driven per scenario.
// Ports   : none; instantiates the bus interface and the bridge.
module tb_peripheral_uart_ahb2apb;
  import peripheral_uart_ahb2apb_pkg::*;

  logic CLK;
  logic RSTN;
  int   checks = 0;
  int   errors = 0;

  // Observations of the last transfer
  int          lat, low_cnt, psel_cnt, acc_cnt, hresp_cnt;
  logic [31:0] pwd_s;
  logic [11:0] pad_s;
  logic        pwr_s, stab;

  peripheral_uart_ahb2apb_if #(.HADDR_WIDTH(32), .APB_ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  peripheral_uart_ahb2apb #(.HADDR_WIDTH(32), .APB_ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  // Single-slave system: the bus-level HREADY is this slave's HREADYOUT.
  assign bus.HREADY = bus.HREADYOUT;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Address phase, then data phase observed until HREADYOUT returns high.
  // Returns in the final (HREADYOUT=1) cycle without advancing the clock.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wdat, input int nwait, input logic slverr);
    bus.HSEL = 1'b1; bus.HADDR = addr; bus.HWRITE = wr; bus.HSIZE = sz;
    bus.HTRANS = HTRANS_NONSEQ; bus.HPROT = 4'b0011;
    tick();
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HWDATA = wdat;
    lat = -1; low_cnt = 0; psel_cnt = 0; acc_cnt = 0; hresp_cnt = 0;
    pwd_s = '0; pad_s = '0; pwr_s = 1'b0; stab = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (!bus.HREADYOUT) low_cnt++;
      if (bus.HRESP) hresp_cnt++;
      bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
      if (bus.PSEL) begin
        if (psel_cnt == 0) begin
          pad_s = bus.PADDR; pwd_s = bus.PWDATA; pwr_s = bus.PWRITE;
        end else if (bus.PADDR !== pad_s || bus.PWDATA !== pwd_s || bus.PWRITE !== pwr_s) begin
          stab = 1'b0;
        end
        psel_cnt++;
        if (bus.PENABLE) begin
          bus.PREADY  = (acc_cnt >= nwait);
          bus.PSLVERR = slverr & bus.PREADY;
          acc_cnt++;
        end
      end
      if (bus.HREADYOUT) begin
        lat = k;
        break;
      end
      tick();
    end
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    bus.HSEL = 0; bus.HADDR = '0; bus.HWDATA = '0; bus.HWRITE = 0; bus.HSIZE = '0;
    bus.HBURST = '0; bus.HPROT = '0; bus.HTRANS = HTRANS_IDLE; bus.HMASTLOCK = 0;
    bus.PRDATA = '0; bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
    tick(); tick();
    checks++; if (bus.PSEL !== 1'b0)      begin errors++; $display("FAIL rst_psel got %b exp 0", bus.PSEL); end
    checks++; if (bus.PENABLE !== 1'b0)   begin errors++; $display("FAIL rst_penable got %b exp 0", bus.PENABLE); end
    checks++; if (bus.PWRITE !== 1'b0)    begin errors++; $display("FAIL rst_pwrite got %b exp 0", bus.PWRITE); end
    checks++; if (bus.PADDR !== 12'h000)  begin errors++; $display("FAIL rst_paddr got %h exp 000", bus.PADDR); end
    checks++; if (bus.PWDATA !== 32'h0)   begin errors++; $display("FAIL rst_pwdata got %h exp 0", bus.PWDATA); end
    checks++; if (bus.HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hreadyout got %b exp 1", bus.HREADYOUT); end
    checks++; if (bus.HRESP !== 1'b0)     begin errors++; $display("FAIL rst_hresp got %b exp 0", bus.HRESP); end
    checks++; if (bus.HRDATA !== 32'h0)   begin errors++; $display("FAIL rst_hrdata got %h exp 0", bus.HRDATA); end
`ifdef PERIPHERAL_UART_AHB2APB_APB4_EN
    checks++; if (bus.PSTRB !== 4'h0)     begin errors++; $display("FAIL rst_pstrb got %h exp 0", bus.PSTRB); end
    checks++; if (bus.PPROT !== 3'h0)     begin errors++; $display("FAIL rst_pprot got %h exp 0", bus.PPROT); end
`endif
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_word_write;
    xfer(32'h0000_000C, 1'b1, HSIZE_WORD, 32'hDEADBEEF, 0, 1'b0);
    checks++; if (lat !== 4)               begin errors++; $display("FAIL ww_latency got %0d exp 4", lat); end
    checks++; if (low_cnt !== 3)           begin errors++; $display("FAIL ww_hreadyout_low got %0d exp 3", low_cnt); end
    checks++; if (psel_cnt !== 2)          begin errors++; $display("FAIL ww_psel_cycles got %0d exp 2", psel_cnt); end
    checks++; if (acc_cnt !== 1)           begin errors++; $display("FAIL ww_access_cycles got %0d exp 1", acc_cnt); end
    checks++; if (pad_s !== 12'h00C)       begin errors++; $display("FAIL ww_paddr got %h exp 00c", pad_s); end
    checks++; if (pwd_s !== 32'hDEADBEEF)  begin errors++; $display("FAIL ww_pwdata got %h exp deadbeef", pwd_s); end
    checks++; if (pwr_s !== 1'b1)          begin errors++; $display("FAIL ww_pwrite got %b exp 1", pwr_s); end
    checks++; if (hresp_cnt !== 0)         begin errors++; $display("FAIL ww_hresp got %0d exp 0", hresp_cnt); end
`ifdef PERIPHERAL_UART_AHB2APB_APB4_EN
    checks++; if (bus.PSTRB !== 4'b1111)   begin errors++; $display("FAIL ww_pstrb got %b exp 1111", bus.PSTRB); end
    checks++; if (bus.PPROT !== 3'b001)    begin errors++; $display("FAIL ww_pprot got %b exp 001", bus.PPROT); end
`endif
    tick();
  endtask

  task automatic test_lanes;
    xfer(32'h0000_0003, 1'b1, HSIZE_BYTE, 32'h8311_2233, 0, 1'b0);
    checks++; if (pwd_s !== 32'h0000_0083) begin errors++; $display("FAIL bw3_pwdata got %h exp 00000083", pwd_s); end
    checks++; if (pad_s !== 12'h003)       begin errors++; $display("FAIL bw3_paddr got %h exp 003", pad_s); end
`ifdef PERIPHERAL_UART_AHB2APB_APB4_EN
    checks++; if (bus.PSTRB !== 4'b0001)   begin errors++; $display("FAIL bw3_pstrb got %b exp 0001", bus.PSTRB); end
`endif
    tick();
    xfer(32'h0000_0001, 1'b1, HSIZE_BYTE, 32'h8311_2233, 0, 1'b0);
    checks++; if (pwd_s !== 32'h0000_0022) begin errors++; $display("FAIL bw1_pwdata got %h exp 00000022", pwd_s); end
    tick();
    bus.PRDATA = 32'hABCD_EF60;
    xfer(32'h0000_0005, 1'b0, HSIZE_BYTE, 32'h0, 0, 1'b0);
    checks++; if (lat !== 3)               begin errors++; $display("FAIL br_latency got %0d exp 3", lat); end
    checks++; if (bus.HRDATA !== 32'h6060_6060) begin errors++; $display("FAIL br_hrdata got %h exp 60606060", bus.HRDATA); end
    checks++; if (pad_s !== 12'h005)       begin errors++; $display("FAIL br_paddr got %h exp 005", pad_s); end
    checks++; if (pwd_s !== 32'h0)         begin errors++; $display("FAIL br_pwdata got %h exp 0", pwd_s); end
    checks++; if (pwr_s !== 1'b0)          begin errors++; $display("FAIL br_pwrite got %b exp 0", pwr_s); end
`ifdef PERIPHERAL_UART_AHB2APB_APB4_EN
    checks++; if (bus.PSTRB !== 4'b0000)   begin errors++; $display("FAIL br_pstrb got %b exp 0000", bus.PSTRB); end
`endif
    tick();
    bus.PRDATA = 32'h0;
    xfer(32'h0000_0006, 1'b1, HSIZE_HALF, 32'hBEEF_1234, 0, 1'b0);
    checks++; if (pwd_s !== 32'h0000_BEEF) begin errors++; $display("FAIL hw_pwdata got %h exp 0000beef", pwd_s); end
    checks++; if (bus.HRDATA !== 32'h6060_6060) begin errors++; $display("FAIL hw_hrdata_hold got %h exp 60606060", bus.HRDATA); end
`ifdef PERIPHERAL_UART_AHB2APB_APB4_EN
    checks++; if (bus.PSTRB !== 4'b0011)   begin errors++; $display("FAIL hw_pstrb got %b exp 0011", bus.PSTRB); end
`endif
    tick();
    bus.PRDATA = 32'h1234_5678;
    xfer(32'h0000_0002, 1'b0, HSIZE_HALF, 32'h0, 0, 1'b0);
    checks++; if (bus.HRDATA !== 32'h5678_5678) begin errors++; $display("FAIL hr_hrdata got %h exp 56785678", bus.HRDATA); end
    tick();
  endtask

  task automatic test_wait_states;
    bus.PRDATA = 32'h0000_00A5;
    xfer(32'h0000_0010, 1'b0, HSIZE_WORD, 32'h0, 3, 1'b0);
    checks++; if (acc_cnt !== 4)           begin errors++; $display("FAIL ws_access_cycles got %0d exp 4", acc_cnt); end
    checks++; if (lat !== 6)               begin errors++; $display("FAIL ws_latency got %0d exp 6", lat); end
    checks++; if (stab !== 1'b1)           begin errors++; $display("FAIL ws_apb_stable got %b exp 1", stab); end
    checks++; if (pad_s !== 12'h010)       begin errors++; $display("FAIL ws_paddr got %h exp 010", pad_s); end
    checks++; if (bus.HRDATA !== 32'h0000_00A5) begin errors++; $display("FAIL ws_hrdata got %h exp 000000a5", bus.HRDATA); end
    tick();
  endtask

  task automatic test_slverr;
    bus.PRDATA = 32'hFFFF_FFFF;
    xfer(32'h0000_0008, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b1);
    checks++; if (lat !== 4)               begin errors++; $display("FAIL se_latency got %0d exp 4", lat); end
    checks++; if (low_cnt !== 3)           begin errors++; $display("FAIL se_hreadyout_low got %0d exp 3", low_cnt); end
    checks++; if (hresp_cnt !== 2)         begin errors++; $display("FAIL se_hresp_cycles got %0d exp 2", hresp_cnt); end
    checks++; if (bus.HRDATA !== 32'h0000_00A5) begin errors++; $display("FAIL se_hrdata_hold got %h exp 000000a5", bus.HRDATA); end
    // A NONSEQ presented during the second error cycle must be ignored.
    bus.HSEL = 1'b1; bus.HADDR = 32'h4; bus.HWRITE = 1'b0; bus.HSIZE = HSIZE_WORD; bus.HTRANS = HTRANS_NONSEQ;
    tick();
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE;
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin errors++; $display("FAIL se_err2_no_accept got rdy=%b resp=%b exp rdy=1 resp=0", bus.HREADYOUT, bus.HRESP); end
    tick();
    checks++; if (bus.PSEL !== 1'b0)       begin errors++; $display("FAIL se_no_apb got %b exp 0", bus.PSEL); end
  endtask

  task automatic test_size_err_busy;
    xfer(32'h0000_0000, 1'b1, 3'b011, 32'h1234_5678, 0, 1'b0);
    checks++; if (psel_cnt !== 0)          begin errors++; $display("FAIL sz_psel got %0d exp 0", psel_cnt); end
    checks++; if (lat !== 2)               begin errors++; $display("FAIL sz_latency got %0d exp 2", lat); end
    checks++; if (hresp_cnt !== 2)         begin errors++; $display("FAIL sz_hresp_cycles got %0d exp 2", hresp_cnt); end
    tick();
    bus.HSEL = 1'b1; bus.HADDR = 32'h0; bus.HWRITE = 1'b0; bus.HSIZE = HSIZE_WORD; bus.HTRANS = HTRANS_BUSY;
    tick();
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.PSEL !== 1'b0)
      begin errors++; $display("FAIL busy_okay got rdy=%b resp=%b psel=%b exp 1 0 0", bus.HREADYOUT, bus.HRESP, bus.PSEL); end
    bus.HTRANS = HTRANS_IDLE;
    tick();
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.PSEL !== 1'b0)
      begin errors++; $display("FAIL idle_okay got rdy=%b psel=%b exp 1 0", bus.HREADYOUT, bus.PSEL); end
    bus.HSEL = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access;
    bus.PREADY = 1'b0;
    bus.HSEL = 1'b1; bus.HADDR = 32'hC; bus.HWRITE = 1'b0; bus.HSIZE = HSIZE_WORD; bus.HTRANS = HTRANS_NONSEQ;
    tick();
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE;
    tick();
    checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1)
      begin errors++; $display("FAIL ra_in_access got psel=%b pen=%b exp 1 1", bus.PSEL, bus.PENABLE); end
    #2 RSTN = 1'b0;
    #1;
    checks++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0)
      begin errors++; $display("FAIL ra_async_drop got psel=%b pen=%b exp 0 0", bus.PSEL, bus.PENABLE); end
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.PADDR !== 12'h0)
      begin errors++; $display("FAIL ra_async_state got rdy=%b paddr=%h exp 1 000", bus.HREADYOUT, bus.PADDR); end
    tick();
    RSTN = 1'b1; bus.PREADY = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    bus.PRDATA = 32'h1122_3344;
    xfer(32'h0000_0004, 1'b0, HSIZE_WORD, 32'h0, 0, 1'b0);
    checks++; if (bus.HRDATA !== 32'h1122_3344) begin errors++; $display("FAIL b2b_first got %h exp 11223344", bus.HRDATA); end
    // Accept in DONE
    bus.HSEL = 1'b1; bus.HADDR = 32'h8; bus.HWRITE = 1'b0; bus.HSIZE = HSIZE_WORD; bus.HTRANS = HTRANS_NONSEQ;
    tick();
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.PRDATA = 32'h5566_7788;
    checks++; if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0 || bus.PADDR !== 12'h008)
      begin errors++; $display("FAIL b2b_setup got psel=%b pen=%b paddr=%h exp 1 0 008", bus.PSEL, bus.PENABLE, bus.PADDR); end
    tick();
    checks++; if (bus.PENABLE !== 1'b1)    begin errors++; $display("FAIL b2b_access got %b exp 1", bus.PENABLE); end
    tick();
    checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'h5566_7788)
      begin errors++; $display("FAIL b2b_second got rdy=%b hrdata=%h exp 1 55667788", bus.HREADYOUT, bus.HRDATA); end
    tick();
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_lanes();
    test_wait_states();
    test_slverr();
    test_size_err_busy();
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
